// File: rtl/dmem_sram_bridge.sv
// dmem_sram_bridge
//   Bridges the CPU memory stage (byte-enable load/store interface) onto an
//   SRAM-like request/handshake bus with one transaction in flight at a time.
//
//   Ports
//     clk, rst            clock, synchronous active-low reset
//     cpu_ren/cpu_wen     memory-stage read/write byte enables
//     cpu_size/addr/wdata access size, effective address, lane-aligned store data
//     cpu_flush           exception flush of the memory stage
//     cpu_ext_stall       pipeline held by another source
//     cpu_rdata/cpu_stall load data and hold request back to the pipeline
//     data_*              bus side: req/wr/size/addr/wstrb/wdata out,
//                         addr_ok/data_ok/rdata in
module dmem_sram_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  cpu_ren,
  input  logic [3:0]  cpu_wen,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_flush,
  input  logic        cpu_ext_stall,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } busReq_t;

  state_t      state, nextState;
  busReq_t     curReq, latReq;
  logic [31:0] rdataR;
  logic        cancel;
  logic        access, issue, complete;

  assign access   = (|cpu_ren) | (|cpu_wen);
  // A flushed instruction never starts a bus access from IDLE.
  assign issue    = (state == IDLE) & access & ~cpu_flush;
  assign complete = (state == DATA) & data_data_ok;

  assign curReq = '{wr: |cpu_wen, size: cpu_size, addr: cpu_addr,
                    strb: cpu_wen, wdata: cpu_wdata};

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (issue)         nextState = data_addr_ok ? DATA : ADDR;
      ADDR: if (data_addr_ok)  nextState = DATA;
      DATA: if (data_data_ok)  nextState = cpu_ext_stall ? DONE : IDLE;
      DONE: if (!cpu_ext_stall) nextState = IDLE;
      default:                 nextState = IDLE;
    endcase
  end

  // Outputs. IDLE presents the live CPU request so a zero-wait slave can
  // accept it in the same cycle; later states replay the latched copy so the
  // fields stay stable even if the pipeline inputs move.
  always_comb begin
    data_req   = 1'b0;
    cpu_stall  = 1'b0;
    data_wr    = latReq.wr;
    data_size  = latReq.size;
    data_addr  = latReq.addr;
    data_wstrb = latReq.strb;
    data_wdata = latReq.wdata;
    case (state)
      IDLE: begin
        data_req   = issue;
        cpu_stall  = issue;
        data_wr    = curReq.wr;
        data_size  = curReq.size;
        data_addr  = curReq.addr;
        data_wstrb = curReq.strb;
        data_wdata = curReq.wdata;
      end
      ADDR: begin
        data_req  = 1'b1;
        cpu_stall = 1'b1;
      end
      DATA:    cpu_stall = ~data_data_ok;
      default: cpu_stall = 1'b0;
    endcase
    cpu_rdata = complete ? data_rdata : rdataR;
    if (!rst) begin
      data_req  = 1'b0;
      cpu_stall = 1'b0;
      cpu_rdata = 32'b0;
    end
  end

  // Request latch, returned-data hold and flush cancel.
  // A flush after the request left IDLE cannot retract it from the slave, so
  // the transaction runs to completion and only its result is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      latReq <= '0;
      rdataR <= 32'b0;
      cancel <= 1'b0;
    end else begin
      if (issue) latReq <= curReq;
      if (complete) begin
        if (!(cancel | cpu_flush)) rdataR <= data_rdata;
        cancel <= 1'b0;
      end else if ((state == ADDR || state == DATA) && cpu_flush) begin
        cancel <= 1'b1;
      end
    end
  end

endmodule

// File: doc/dmem_sram_bridge.md
DMEM_SRAM_BRIDGE -- requirements
Module: dmem_sram_bridge

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 cpu_ren  in  4  memory-stage read byte enables; nonzero means a load.
REQ-005 cpu_wen  in  4  memory-stage write byte enables; nonzero means a store.
REQ-006 cpu_size  in  2  access size (0 byte, 1 half, 2 word).
REQ-007 cpu_addr  in  32  memory-stage effective address.
REQ-008 cpu_wdata  in  32  store data, already lane-aligned.
REQ-009 cpu_flush  in  1  exception flush of the memory stage.
REQ-010 cpu_ext_stall  in  1  pipeline held by another source this cycle.
REQ-011 cpu_rdata  out  32  load data returned to the memory stage.
REQ-012 cpu_stall  out  1  memory stage must hold; access not yet complete.
REQ-013 data_req  out  1  bus request valid.
REQ-014 data_wr  out  1  1 = write, 0 = read.
REQ-015 data_size  out  2  bus access size.
REQ-016 data_addr  out  32  bus address.
REQ-017 data_wstrb  out  4  byte write strobes.
REQ-018 data_wdata  out  32  bus write data.
REQ-019 data_addr_ok  in  1  slave accepted the request this cycle.
REQ-020 data_data_ok  in  1  slave returns read data or write ack this cycle.
REQ-021 data_rdata  in  32  read data, valid with data_data_ok.

Function
REQ-022 access SHALL be (|cpu_ren)|(|cpu_wen); accesses with both zero (e.g. misaligned, suppressed) never reach the bus.
REQ-023 FSM states SHALL be IDLE, ADDR, DATA, DONE.
REQ-024 IDLE: data_req = access & ~cpu_flush; request fields driven directly from cpu_* inputs and latched on every cycle data_req=1.
REQ-025 IDLE transitions: data_req & data_addr_ok -> DATA; data_req & ~data_addr_ok -> ADDR; otherwise stay.
REQ-026 ADDR: data_req=1, fields from latched copy; cpu_flush SHALL NOT withdraw the request; data_addr_ok -> DATA.
REQ-027 DATA: data_req=0; on data_data_ok capture data_rdata into rdata_r and go to DONE if cpu_ext_stall else IDLE.
REQ-028 DONE: data_req=0; go to IDLE when cpu_ext_stall=0.
REQ-029 data_wr = |wen, data_wstrb = wen, data_size = size, data_addr = addr, data_wdata = wdata of the issuing/latched request.
REQ-030 cpu_stall SHALL be 1 in IDLE when data_req=1, in ADDR, and in DATA without data_data_ok; 0 otherwise (including DONE and the data_data_ok cycle).
REQ-031 cpu_rdata SHALL equal data_rdata in the DATA cycle with data_data_ok, else rdata_r.
REQ-032 cpu_flush asserted in ADDR or DATA SHALL set a cancel flag; the transaction completes on the bus, rdata_r is not updated, cancel clears on completion; cpu_stall behaves per REQ-030.
REQ-033 At most one outstanding transaction; no new request before the previous data_data_ok.
REQ-034 Minimum latency: request in cycle N with addr_ok, data_ok in N+1, cpu_stall low in N+1.
REQ-035 data_data_ok outside DATA SHALL be ignored.

Reset
REQ-036 rst=0 at a clock edge SHALL force state IDLE, rdata_r=0, cancel=0, latched fields=0.
REQ-037 While rst=0, data_req and cpu_stall SHALL be 0 and cpu_rdata 0.
REQ-038 Reset mid-transaction abandons it; the slave shares the same reset.

Verification
REQ-039 Load word: cpu_ren=4'hF, addr=0x0000_1000, addr_ok same cycle, data_ok next with 0xDEADBEEF -> one req cycle, data_wr=0, cpu_rdata=0xDEADBEEF, stall high exactly 1 cycle.
REQ-040 Byte store: cpu_wen=4'b0100, addr=0x0000_2002, wdata=0x00AB0000, addr_ok after 3 cycles -> data_req held 4 cycles with stable fields, data_wstrb=4'b0100, stall until data_ok.
REQ-041 Load completes with cpu_ext_stall=1 for 2 more cycles -> state DONE, cpu_stall=0, cpu_rdata holds value, no second request.
REQ-042 cpu_flush in IDLE with access -> data_req=0, no transaction; flush in ADDR -> request still accepted, data discarded, rdata_r unchanged.
REQ-043 rst=0 while in DATA -> next cycle IDLE, outputs zero; spurious data_data_ok afterwards ignored.
REQ-044 Back-to-back loads to 0x10, 0x14 with 0-wait slave -> second data_req in cycle after first data_ok, returned data in order.
